skid_buffer: RTL and testbench

SKID_BUFFER -- requirements
Module: skid_buffer

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/skid_buffer.sv | 93 +++++++++
 tb/tb_skid_buffer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default payload width, skid buffer state
// encoding and the state-to-occupancy mapping.
package pipe_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    function automatic logic [1:0] occupancy_of(input skid_state_t s);
        case (s)
            EMPTY:   return 2'd0;
            BUSY:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: fully registered valid/ready handshake on both sides,
// with a main register driving out_data and a skid register absorbing one beat.
module skid_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    skid_state_t           state;
    skid_state_t           next_state;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  accept;
    logic                  drain;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;

    // Handshakes use only flopped ready/valid, so no input reaches an output combinationally.
    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    next_state   = BUSY;
                end
            end
            BUSY: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    next_state = FULL;
                end else if (drain) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    load_main_skid = 1'b1;
                    next_state     = BUSY;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            main_q    <= '0;
        end else begin
            state     <= next_state;
            out_valid <= (next_state != EMPTY);
            in_ready  <= (next_state != FULL);
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
        end
    end

    // The skid entry is only ever read in FULL, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_q <= in_data;
        end
    end

    assign out_data  = main_q;
    assign occupancy = occupancy_of(state);

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: a queue-based reference model checked
// every cycle, plus directed cases with literal expected values.
module tb_skid_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int unsigned total;
    int unsigned bad;
    bit          check_en;

    // Reference model: beats held, in acceptance order, plus the registered ready.
    logic [31:0] q[$];
    bit          ready_m;
    int unsigned acc_cnt;
    int unsigned drain_cnt;

    skid_buffer #(
        .DATA_WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        bit drn;
        acc = in_valid && ready_m;
        drn = (q.size() > 0) && out_ready;
        if (rst) begin
            q.delete();
            ready_m = 1'b0;
        end else begin
            if (drn) begin
                void'(q.pop_front());
                drain_cnt++;
            end
            if (acc) begin
                q.push_back(in_data);
                acc_cnt++;
            end
            ready_m = (q.size() != 2);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_in_ready", 32'(in_ready), 32'(ready_m));
            chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("m_occupancy", 32'(occupancy), 32'(q.size()));
            if (q.size() > 0) chk("m_out_data", out_data, q[0]);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int unsigned base;
        total     = 0;
        bad       = 0;
        check_en  = 1'b0;
        ready_m   = 1'b0;
        acc_cnt   = 0;
        drain_cnt = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check_en = 1'b1;
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_occupancy", 32'(occupancy), 32'd0);
            chk("rst_out_data", out_data, 32'h0);
        end

        // A beat offered on the release edge is not accepted
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h0000_0055;
        step();
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_occupancy", 32'(occupancy), 32'd0);

        // Single beat
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        step();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", out_data, 32'hDEAD_BEEF);
        in_valid = 1'b0;
        step();
        chk("single_gone", 32'(out_valid), 32'd0);

        // Backpressure fills both entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hCAFE_BABE;
        step();
        chk("bp_occ1", 32'(occupancy), 32'd1);
        in_data = 32'h1234_5678;
        step();
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_data_a", out_data, 32'hCAFE_BABE);
        in_data = 32'hBAD0_BAD0;
        step();
        chk("bp_hold_data", out_data, 32'hCAFE_BABE);
        chk("bp_hold_occ", 32'(occupancy), 32'd2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_data_b", out_data, 32'h1234_5678);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: one beat per cycle with no bubble
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data", out_data, 32'(i));
        end
        in_valid = 1'b0;
        step();

        // Random stalls, 1000 accepted beats against the model
        base = acc_cnt;
        for (int c = 0; c < 20000 && acc_cnt < base + 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("rand_accepts", acc_cnt - base, 32'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rand_drained", drain_cnt, acc_cnt);

        // Reset while FULL discards everything
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA_0001;
        step();
        in_data = 32'hAAAA_0002;
        step();
        chk("mid_full", 32'(occupancy), 32'd2);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            step();
            chk("mid_no_reappear", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
